// File: rtl/pipe_seq_pkg.sv
// pipe_seq_pkg: state codes and trap causes shared by the pipeline sequencer
package pipe_seq_pkg;
   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      EXEC   = 4'd3,
      MEM    = 4'd4,
      WB     = 4'd5,
      TRAP   = 4'd6
   } state_t;
   localparam logic [1:0] CAUSE_ECALL  = 2'd0;
   localparam logic [1:0] CAUSE_EBREAK = 2'd1;
   localparam logic [1:0] CAUSE_BUS_TO = 2'd2;
endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// pipe_seq_ctrl_if: sequencer bundle towards IFU, decoder, ALU/LSU and register file
interface pipe_seq_ctrl_if;
   logic       run;
   logic       ifu_valid;
   logic       ifu_req;
   logic       dec_load_en;
   logic       dec_store_en;
   logic       dec_jump_en;
   logic       dec_branch_en;
   logic       dec_ecall;
   logic       dec_ebreak;
   logic       br_taken;
   logic       lsu_req;
   logic       lsu_ready;
   logic [3:0] cycle_cnt;
   logic       ifu_dec_stall;
   logic       rf_we;
   logic       pc_we;
   logic       flush;
   logic       trap;
   logic [1:0] trap_cause;
   logic       busy;
   modport master (
      input  run, ifu_valid, dec_load_en, dec_store_en, dec_jump_en, dec_branch_en,
             dec_ecall, dec_ebreak, br_taken, lsu_ready,
      output ifu_req, lsu_req, cycle_cnt, ifu_dec_stall, rf_we, pc_we, flush, trap,
             trap_cause, busy
   );
   modport slave (
      output run, ifu_valid, dec_load_en, dec_store_en, dec_jump_en, dec_branch_en,
             dec_ecall, dec_ebreak, br_taken, lsu_ready,
      input  ifu_req, lsu_req, cycle_cnt, ifu_dec_stall, rf_we, pc_we, flush, trap,
             trap_cause, busy
   );
endinterface

// File: rtl/pipe_seq_perf.sv
// pipe_seq_perf: free-running retire and stall counters, wrapping at 2^32
module pipe_seq_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        retire,
   input  logic        stall,
   output logic [31:0] retire_cnt,
   output logic [31:0] stall_cnt
);
   // count WB cycles and wait cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         retire_cnt <= retire_cnt + {31'd0, retire};
         stall_cnt  <= stall_cnt + {31'd0, stall};
      end
   end
endmodule

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: multi-cycle sequencer FSM; PIPE_SEQ_PERF_CNT_EN adds retire/stall counters
module pipe_seq_ctrl
   import pipe_seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input logic            hclk,
   input logic            hrst,
   pipe_seq_ctrl_if.master bus
`ifdef PIPE_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]    retire_cnt,
   output logic [31:0]    stall_cnt
`endif
);
   localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);
   state_t     state, nxt;
   logic       xfer, nowb;
   logic [3:0] tcnt;
   logic [1:0] cause;
   // state register, MEM wait counter, EXEC-latched flags and sticky trap cause
   always_ff @(posedge hclk) begin
      if (hrst) begin
         state <= IDLE;
         xfer  <= 1'b0;
         nowb  <= 1'b0;
         tcnt  <= 4'd0;
         cause <= CAUSE_ECALL;
      end else begin
         state <= nxt;
         tcnt  <= (state == MEM) ? tcnt + {3'd0, !bus.lsu_ready} : 4'd0;
         if (state == EXEC) begin
            xfer <= bus.dec_jump_en | (bus.dec_branch_en & bus.br_taken);
            nowb <= bus.dec_store_en | bus.dec_branch_en;
         end
         if (nxt == TRAP)
            cause <= (state == MEM) ? CAUSE_BUS_TO : bus.dec_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
      end
   end
   // next state; unused codes fall back to IDLE
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = bus.run ? FETCH : IDLE;
         FETCH:   nxt = bus.ifu_valid ? DECODE : FETCH;
         DECODE:  nxt = EXEC;
         EXEC:    nxt = (bus.dec_ecall | bus.dec_ebreak) ? TRAP :
                        (bus.dec_load_en | bus.dec_store_en) ? MEM : WB;
         MEM:     nxt = bus.lsu_ready ? WB : (tcnt == TO_LAST) ? TRAP : MEM;
         WB:      nxt = bus.run ? FETCH : IDLE;
         TRAP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   assign bus.cycle_cnt     = state;
   assign bus.ifu_req       = state == FETCH;
   assign bus.lsu_req       = state == MEM;
   assign bus.ifu_dec_stall = state != DECODE;
   assign bus.rf_we         = (state == WB) & !nowb;
   assign bus.pc_we         = (state == WB) | (state == TRAP);
   assign bus.flush         = (state == TRAP) | ((state == WB) & xfer);
   assign bus.trap          = state == TRAP;
   assign bus.trap_cause    = cause;
   assign bus.busy          = state != IDLE;
`ifdef PIPE_SEQ_PERF_CNT_EN
   pipe_seq_perf u_perf (
      .clk        (hclk),
      .rst        (hrst),
      .retire     (state == WB),
      .stall      (((state == FETCH) & !bus.ifu_valid) | ((state == MEM) & !bus.lsu_ready)),
      .retire_cnt (retire_cnt),
      .stall_cnt  (stall_cnt)
   );
`endif
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb_pipe_seq_ctrl: table, directed and randomized checks of pipe_seq_ctrl against a trace model
module tb_pipe_seq_ctrl;
   localparam int MEM_TO = 15;
   localparam logic [13:0] RST_EXP = {4'd0, 7'b0010000, 2'd0, 1'b0};
   typedef struct {
      logic        run;
      logic        iv;
      logic        lr;
      logic [6:0]  dec;
      logic [13:0] exp;
   } vec_t;
   logic hclk = 1'b0;
   logic hrst = 1'b1;
   pipe_seq_ctrl_if bus ();
`ifdef PIPE_SEQ_PERF_CNT_EN
   logic [31:0] retire_cnt, stall_cnt;
`endif
   pipe_seq_ctrl #(.MEM_TIMEOUT(MEM_TO)) dut (
      .hclk       (hclk),
      .hrst       (hrst),
      .bus        (bus)
`ifdef PIPE_SEQ_PERF_CNT_EN
      ,
      .retire_cnt (retire_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );
   always #5 hclk = ~hclk;
   vec_t        q[$];
   vec_t        tbl[5];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   string       tag = "reset";
   logic [6:0]  cur_flags;
   bit          m_idle;
   logic [1:0]  m_cause;
   logic [31:0] m_retire, m_stall;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic vec_t mk(input logic run, input logic iv, input logic [13:0] exp);
      vec_t v;
      v.run = run;
      v.iv  = iv;
      v.lr  = 1'b0;
      v.dec = 7'd0;
      v.exp = exp;
      return v;
   endfunction

   task automatic check(input logic [13:0] exp);
      logic [13:0] act;
      act = {bus.cycle_cnt, bus.ifu_req, bus.lsu_req, bus.ifu_dec_stall, bus.rf_we, bus.pc_we,
             bus.flush, bus.trap, bus.trap_cause, bus.busy};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got cc=%0d strobes=%b expected cc=%0d strobes=%b",
                  tag, cyc, act[13:10], act[9:0], exp[13:10], exp[9:0]);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.run       = v.run;
      bus.ifu_valid = v.iv;
      bus.lsu_ready = v.lr;
      {bus.dec_load_en, bus.dec_store_en, bus.dec_jump_en, bus.dec_branch_en,
       bus.dec_ecall, bus.dec_ebreak, bus.br_taken} = v.dec;
   endtask

   task automatic run_q();
      foreach (q[i]) begin
         drive(q[i]);
         check(q[i].exp);
         @(posedge hclk);
         @(negedge hclk);
         cyc++;
      end
      q.delete();
`ifdef PIPE_SEQ_PERF_CNT_EN
      n_cmp++;
      if (retire_cnt !== m_retire) begin
         n_err++;
         $display("FAIL %s retire_cnt: got %0d expected %0d", tag, retire_cnt, m_retire);
      end
      n_cmp++;
      if (stall_cnt !== m_stall) begin
         n_err++;
         $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, m_stall);
      end
`endif
   endtask

   // one model cycle: phase code, inputs, and the outputs that phase must show
   task automatic push(input logic [3:0] cc, input logic r, input logic iv, input logic lr,
                       input logic rfw, input logic fl);
      vec_t v;
      v.run = r;
      v.iv  = iv;
      v.lr  = lr;
      v.dec = (cc == 4'd3) ? cur_flags : 7'($urandom);
      v.exp = {cc, cc == 4'd1, cc == 4'd4, cc != 4'd2, rfw, (cc == 4'd5) || (cc == 4'd6), fl,
               cc == 4'd6, m_cause, cc != 4'd0};
      q.push_back(v);
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 jump, 4 branch, 5 ecall, 6 ebreak
   task automatic instr(input int kind, input int fw, input int mw, input bit taken,
                        input bit drop, input int gap);
      logic r, ld, st, jp, br, ec, eb;
      ld = kind == 1;
      st = kind == 2;
      jp = kind == 3;
      br = kind == 4;
      ec = kind == 5;
      eb = (kind == 6) || (ec && rb());
      if (ec | eb) begin
         ld = rb();
         st = !ld && rb();
      end
      cur_flags = {ld, st, jp, br, ec, eb, br ? logic'(taken) : rb()};
      if (m_idle) begin
         for (int i = 0; i < gap; i++) push(4'd0, 1'b0, rb(), rb(), 1'b0, 1'b0);
         push(4'd0, 1'b1, rb(), rb(), 1'b0, 1'b0);
      end
      for (int i = 0; i < fw; i++) push(4'd1, 1'b1, 1'b0, rb(), 1'b0, 1'b0);
      push(4'd1, 1'b1, 1'b1, rb(), 1'b0, 1'b0);
      m_stall += 32'(fw);
      r = !drop;
      push(4'd2, r, rb(), rb(), 1'b0, 1'b0);
      push(4'd3, r, rb(), rb(), 1'b0, 1'b0);
      if (ec | eb) begin
         m_cause = ec ? 2'd0 : 2'd1;
         push(4'd6, r, rb(), rb(), 1'b0, 1'b1);
         m_idle = 1;
      end else if ((ld | st) && mw >= MEM_TO) begin
         for (int i = 0; i < MEM_TO; i++) push(4'd4, r, rb(), 1'b0, 1'b0, 1'b0);
         m_stall += 32'(MEM_TO);
         m_cause = 2'd2;
         push(4'd6, r, rb(), rb(), 1'b0, 1'b1);
         m_idle = 1;
      end else begin
         if (ld | st) begin
            for (int i = 0; i < mw; i++) push(4'd4, r, rb(), 1'b0, 1'b0, 1'b0);
            push(4'd4, r, rb(), 1'b1, 1'b0, 1'b0);
            m_stall += 32'(mw);
         end
         push(4'd5, r, rb(), rb(), !(st | br), jp | (br & taken));
         m_retire++;
         m_idle = !r;
      end
   endtask

   initial begin
      tbl[0] = mk(1'b1, 1'b0, {4'd0, 7'b0010000, 2'd0, 1'b0});
      tbl[1] = mk(1'b1, 1'b1, {4'd1, 7'b1010000, 2'd0, 1'b1});
      tbl[2] = mk(1'b1, 1'b0, {4'd2, 7'b0000000, 2'd0, 1'b1});
      tbl[3] = mk(1'b1, 1'b0, {4'd3, 7'b0010000, 2'd0, 1'b1});
      tbl[4] = mk(1'b1, 1'b0, {4'd5, 7'b0011100, 2'd0, 1'b1});
      drive(mk(1'b0, 1'b0, RST_EXP));
      hrst = 1'b1;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      check(RST_EXP);
      hrst = 1'b0;
      m_idle   = 0;
      m_cause  = 2'd0;
      m_retire = 32'd1;
      m_stall  = 32'd0;
      tag = "add_table";
      foreach (tbl[i]) q.push_back(tbl[i]);
      run_q();
      tag = "lw_ready_3rd";
      instr(1, 0, 2, 1'b0, 1'b0, 0);
      run_q();
      tag = "beq_taken";
      instr(4, 0, 0, 1'b1, 1'b0, 0);
      run_q();
      tag = "sw";
      instr(2, 0, 0, 1'b0, 1'b0, 0);
      run_q();
      tag = "lw_ready_at_limit";
      instr(1, 1, MEM_TO - 1, 1'b0, 1'b0, 0);
      run_q();
      tag = "sw_timeout";
      instr(2, 0, MEM_TO, 1'b0, 1'b0, 0);
      run_q();
      tag = "ecall";
      instr(5, 0, 0, 1'b0, 1'b0, 1);
      run_q();
      tag = "run_drop";
      instr(0, 1, 0, 1'b0, 1'b1, 1);
      run_q();
      tag = "idle_park";
      instr(6, 0, 0, 1'b0, 1'b0, 3);
      run_q();
      tag = "rst_mid_mem";
      cur_flags = 7'b1000000;
      push(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push(4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      push(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      m_stall += 32'd2;
      run_q();
      check({4'd4, 7'b0110000, m_cause, 1'b1});
      hrst = 1'b1;
      @(posedge hclk);
      @(negedge hclk);
      check(RST_EXP);
      hrst = 1'b0;
      m_idle   = 1;
      m_cause  = 2'd0;
      m_retire = 32'd0;
      m_stall  = 32'd0;
      tag = "random";
      for (int k = 0; k < 250; k++) begin
         int mw;
         mw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MEM_TO - 2, MEM_TO + 2))
                                          : int'($urandom_range(0, 3));
         instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), mw, 1'($urandom),
               $urandom_range(0, 5) == 0, int'($urandom_range(0, 2)));
         run_q();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
